// File: rtl/axi_sram_pkg.sv
// axi_sram_pkg: shared constants and types for the AXI SRAM slave.
//   RESP_*     : AXI response codes returned on R and B.
//   rd_state_e : one-hot read FSM encoding.
//   wr_state_e : one-hot write FSM encoding.
//   beat_incr  : byte increment between consecutive beats of an INCR burst.
package axi_sram_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      R_IDLE  = 3'b001,
      R_FETCH = 3'b010,
      R_DATA  = 3'b100
   } rd_state_e;

   typedef enum logic [2:0] {
      W_IDLE = 3'b001,
      W_DATA = 3'b010,
      W_RESP = 3'b100
   } wr_state_e;

   function automatic logic [31:0] beat_incr(input logic [2:0] size);
      return 32'd1 << size;
   endfunction

endpackage

// File: rtl/axi_sram_ram.sv
// axi_sram_ram: simple dual-port word RAM, 2^AW x 32 bits.
//   clk             : clock
//   ren/raddr/rdata : synchronous read port; rdata updates one cycle after ren
//   we/waddr/wdata  : byte-enabled write port (we[i] enables byte i)
// A read and a write to the same word in the same cycle return the old word.
// Contents are deliberately not reset.
module axi_sram_ram
   import axi_sram_pkg::*;
#(
   parameter int unsigned AW = 12
) (
   input  logic          clk,
   input  logic          ren,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata,
   input  logic [3:0]    we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata
);

   logic [31:0] mem_q [0:(1 << AW) - 1];
   logic [31:0] rdata_q;

   // Both ports update with non-blocking assignments, so a colliding read
   // samples the pre-write contents.
   always_ff @(posedge clk) begin
      if (ren) begin
         rdata_q <= mem_q[raddr];
      end
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3-style responder backed by an on-chip word SRAM.
//   aclk/aresetn         : clock, asynchronous active-low reset
//   AR/R channel         : one outstanding INCR read burst, 2 cycles per beat
//   AW/W/B channel       : one outstanding INCR write burst with byte strobes
// Byte address BASE_ADDR maps to word 0; out-of-range bursts answer SLVERR.
// lock/cache/prot, burst type and wid are accepted but ignored.
module axi_sram_slave
   import axi_sram_pkg::*;
#(
   parameter int unsigned MEM_AW    = 12,
   parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
   input  logic        aclk,
   input  logic        aresetn,
   // read address
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   // read data
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   // write address
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   // write data
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   // write response
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam logic [31:0] MEM_BYTES = 32'd4 << MEM_AW;

   // ---------------------------------------------------------------- read path
   rd_state_e   r_state_q, r_state_d;
   logic [3:0]  rid_q, rid_d;
   logic [31:0] roff_q, roff_d;
   logic [7:0]  rlen_q, rlen_d;
   logic [2:0]  rsize_q, rsize_d;
   logic [7:0]  rbeat_q, rbeat_d;
   logic        rerr_q, rerr_d;

   logic [31:0] ar_off;
   logic        rlast_w;
   logic        ram_ren;
   logic [31:0] ram_rdata;

   assign ar_off  = araddr - BASE_ADDR;
   assign rlast_w = (rbeat_q == rlen_q);

   always_comb begin
      r_state_d = r_state_q;
      rid_d     = rid_q;
      roff_d    = roff_q;
      rlen_d    = rlen_q;
      rsize_d   = rsize_q;
      rbeat_d   = rbeat_q;
      rerr_d    = rerr_q;
      ram_ren   = 1'b0;
      unique case (r_state_q)
         R_IDLE: begin
            if (arvalid) begin
               rid_d     = arid;
               roff_d    = ar_off;
               rlen_d    = arlen;
               rsize_d   = arsize;
               rbeat_d   = 8'd0;
               // Range is judged once per burst; later beats wrap in the array.
               rerr_d    = !(ar_off < MEM_BYTES);
               r_state_d = R_FETCH;
            end
         end
         R_FETCH: begin
            ram_ren   = 1'b1;
            r_state_d = R_DATA;
         end
         R_DATA: begin
            if (rready) begin
               if (rlast_w) begin
                  r_state_d = R_IDLE;
               end else begin
                  roff_d    = roff_q + beat_incr(rsize_q);
                  rbeat_d   = rbeat_q + 8'd1;
                  r_state_d = R_FETCH;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state_q <= R_IDLE;
         rid_q     <= 4'd0;
         roff_q    <= 32'd0;
         rlen_q    <= 8'd0;
         rsize_q   <= 3'd0;
         rbeat_q   <= 8'd0;
         rerr_q    <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         rid_q     <= rid_d;
         roff_q    <= roff_d;
         rlen_q    <= rlen_d;
         rsize_q   <= rsize_d;
         rbeat_q   <= rbeat_d;
         rerr_q    <= rerr_d;
      end
   end

   // IDLE is the reset state, so ready must also be masked by reset itself.
   assign arready = aresetn && (r_state_q == R_IDLE);
   assign rvalid  = (r_state_q == R_DATA);
   assign rlast   = rvalid && rlast_w;
   // The RAM output register only moves in R_FETCH, so rdata holds under stall.
   assign rdata   = (rvalid && !rerr_q) ? ram_rdata : 32'd0;
   assign rresp   = rerr_q ? RESP_SLVERR : RESP_OKAY;
   assign rid     = rid_q;

   // --------------------------------------------------------------- write path
   wr_state_e   w_state_q, w_state_d;
   logic [3:0]  bid_q, bid_d;
   logic [31:0] woff_q, woff_d;
   logic [7:0]  wlen_q, wlen_d;
   logic [2:0]  wsize_q, wsize_d;
   logic [8:0]  wbeat_q, wbeat_d;
   logic        werr_q, werr_d;
   logic [1:0]  bresp_q, bresp_d;

   logic [31:0] aw_off;
   logic [3:0]  ram_we;

   assign aw_off = awaddr - BASE_ADDR;

   always_comb begin
      w_state_d = w_state_q;
      bid_d     = bid_q;
      woff_d    = woff_q;
      wlen_d    = wlen_q;
      wsize_d   = wsize_q;
      wbeat_d   = wbeat_q;
      werr_d    = werr_q;
      bresp_d   = bresp_q;
      ram_we    = 4'b0000;
      unique case (w_state_q)
         W_IDLE: begin
            if (awvalid) begin
               bid_d     = awid;
               woff_d    = aw_off;
               wlen_d    = awlen;
               wsize_d   = awsize;
               wbeat_d   = 9'd0;
               werr_d    = !(aw_off < MEM_BYTES);
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (wvalid) begin
               // Beats past awlen are absorbed without touching memory.
               if (!werr_q && (wbeat_q <= {1'b0, wlen_q})) begin
                  ram_we = wstrb;
               end
               woff_d  = woff_q + beat_incr(wsize_q);
               // Saturate above any legal len so an overlong burst never aliases.
               wbeat_d = (wbeat_q == 9'h1ff) ? wbeat_q : wbeat_q + 9'd1;
               if (wlast) begin
                  bresp_d   = (werr_q || (wbeat_q != {1'b0, wlen_q})) ? RESP_SLVERR
                                                                       : RESP_OKAY;
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (bready) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state_q <= W_IDLE;
         bid_q     <= 4'd0;
         woff_q    <= 32'd0;
         wlen_q    <= 8'd0;
         wsize_q   <= 3'd0;
         wbeat_q   <= 9'd0;
         werr_q    <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         bid_q     <= bid_d;
         woff_q    <= woff_d;
         wlen_q    <= wlen_d;
         wsize_q   <= wsize_d;
         wbeat_q   <= wbeat_d;
         werr_q    <= werr_d;
         bresp_q   <= bresp_d;
      end
   end

   assign awready = aresetn && (w_state_q == W_IDLE);
   assign wready  = (w_state_q == W_DATA);
   assign bvalid  = (w_state_q == W_RESP);
   assign bid     = bid_q;
   assign bresp   = bresp_q;

   // --------------------------------------------------------------------- RAM
   axi_sram_ram #(
      .AW(MEM_AW)
   ) u_ram (
      .clk  (aclk),
      .ren  (ram_ren),
      .raddr(roff_q[MEM_AW+1:2]),
      .rdata(ram_rdata),
      .we   (ram_we),
      .waddr(woff_q[MEM_AW+1:2]),
      .wdata(wdata)
   );

   logic unused_sigs;
   assign unused_sigs = ^{arburst, arlock, arcache, arprot, awburst, awlock, awcache, awprot,
                          wid, roff_q[31:MEM_AW+2], roff_q[1:0], woff_q[31:MEM_AW+2],
                          woff_q[1:0]};

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI3-style slave (responder) that terminates the cache bridge's AR/R/AW/W/B channels on an on-chip word-addressed SRAM. Serves as simulation and FPGA main memory behind the CPU bridge. Supports INCR bursts, byte strobes, one outstanding read plus one outstanding write. The read and write paths run independently.

Parameters:
MEM_AW, 12, word-address width; memory is 2^MEM_AW 32-bit words (16 KiB by default).
BASE_ADDR, 32'h1c00_0000, byte address mapped to word 0.

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous assert, active-low
arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read address; arburst ignored, always INCR
arlock/arcache/arprot  in  2/4/3  ignored
arvalid  in  1 ; arready  out  1  AR handshake
rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  read data beat
rready  in  1  R accept
awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write address; awburst ignored, always INCR
awlock/awcache/awprot  in  2/4/3  ignored
awvalid  in  1 ; awready  out  1  AW handshake
wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  write beat; wid ignored
wready  out  1  W accept
bid/bresp/bvalid  out  4/2/1  write response
bready  in  1  B accept

Behaviour:
- Reset (aresetn=0, asynchronous): both FSMs go to IDLE, all counters clear. All valid/ready outputs are 0 during reset. rid, rdata, rresp, rlast, bid and bresp reset to 0. Memory contents are not reset.
- Address decode: offset = addr - BASE_ADDR; word index = offset[MEM_AW+1:2]. The address is in range iff offset < 4·2^MEM_AW. The in-range flag is latched at AW/AR acceptance; later beats wrap modulo depth.
- Read FSM states: R_IDLE, R_FETCH, R_DATA.
  - R_IDLE: arready=1. On arvalid, latch arid, address, arlen and arsize, clear beat counter, go to R_FETCH.
  - R_FETCH: RAM read issued (1-cycle synchronous read), go to R_DATA.
  - R_DATA: rvalid=1. rdata, rid and rlast (beat==len) are held stable until rready.
  - On the R handshake: if rlast, go to R_IDLE; else addr += (1<<arsize), beat++, go to R_FETCH.
  - Latency: AR handshake at cycle T gives first rvalid at T+2; back-to-back beats are 2 cycles apart when rready=1.
  - Narrow sizes return the full aligned word.
  - Out of range: rresp=2'b10 (SLVERR) and rdata=0 on every beat. Otherwise rresp=2'b00.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1, wready=0. A W beat arriving before AW waits, held by the master. On AW handshake, latch awid, address, awlen and awsize, and go to W_DATA.
  - W_DATA: wready=1. Each handshake writes wdata under wstrb byte enables (no write if out of range or beat>len), then addr += (1<<awsize), beat++. On the beat with wlast=1, go to W_RESP.
  - W_RESP: bvalid=1, bid=latched awid. Stay until bready, then go to W_IDLE. The earliest AW can be accepted is the cycle after the B handshake.
  - bresp=SLVERR if out of range, or if the wlast position differs from awlen; otherwise OKAY.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data (read-before-write). Ordering between channels is the master's responsibility.
- Reset mid-burst aborts the burst immediately. No partial response is issued after reset release.

Decomposition:
- Package axi_sram_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - read and write state encodings (one-hot, 3 bits each);
  - function beat_incr(size), returning 1<<size.
- One sub-module, axi_sram_ram: simple dual-port RAM with a synchronous read port (ren, raddr, rdata), a byte-enabled write port (we[3:0], waddr, wdata), and read-before-write collision behaviour.

Test Plan:
1. Preload word 0x10 = 32'hDEADBEEF. Issue AR addr=BASE+0x40, len=0, size=2, id=0. Expect rvalid at T+2 with rdata=DEADBEEF, rid=0, rlast=1, rresp=0.
2. Burst read: len=3, id=1, addr=BASE+0x100, with rready low for 3 cycles on beat 1. Expect 4 beats of words 0x40..0x43 in order, data held stable while stalled, rlast only on beat 4.
3. Burst write: AW/W issued together, len=3, wstrb=4'hF, data 1..4 at BASE+0x200. Expect wready=0 until the AW handshake, then 4 beats written, bvalid with bid=1 and bresp=0. Read-back returns 1,2,3,4.
4. Partial strobe: word holds 32'h11223344; write 32'hAABBCCDD with wstrb=4'b0011. Read-back gives 32'h1122CCDD.
5. Out of range: araddr=BASE+0x4000 (MEM_AW=12) gives rresp=2'b10 and rdata=0. A write with awaddr=BASE+0x4000 gives bresp=2'b10, and memory is unchanged.
6. Concurrency and reset: read and write to the same word in the same cycle return the old value; a later read returns the new value. Dropping aresetn during beat 2 of a read burst takes rvalid, arready and all other valid/ready outputs to 0 immediately; after release, arready=1 and a fresh burst completes correctly.
